seq_detect_ctrl: RTL and testbench
==================================

Name: seq_detect_ctrl

Overview:
Controller that arms, runs and terminates a programmable serial pattern-detection job on a bit stream with a valid qualifier. The block latches a pattern, a target match count and a timeout on start, and counts overlapping pattern matches. It finishes with done when the target is reached, or with timeout when the bit budget runs out. It sits between a host/sequencer (start/busy/done handshake) and the serial data source. It generalises the fixed Moore detector into a reusable, job-based resource.

Parameters:
PAT_W, 4, pattern length in bits (>=2)
CNT_W, 8, width of match target/counter
TMO_W, 16, width of bit-budget timeout/counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  job request, sampled in IDLE only
cfg_pattern  input  PAT_W  pattern; MSB is the first bit received
cfg_target  input  CNT_W  matches required for done
cfg_timeout  input  TMO_W  max valid bits per job; 0 = no timeout
din_valid  input  1  din qualifier
din  input  1  serial data bit
busy  output  1  job in progress (RUN state)
done  output  1  one-cycle pulse: target reached
timeout  output  1  one-cycle pulse: bit budget exhausted
match_pulse  output  1  one-cycle pulse per detected match
match_cnt  output  CNT_W  matches in current/last job

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - busy, done, timeout and match_pulse = 0.
  - match_cnt, shift register, fill counter and bit counter = 0.
  - Mid-job reset aborts the job immediately. No done or timeout pulse is produced.
- All outputs are registered. busy=1 iff state==RUN. done=1 iff state==DONE. timeout=1 iff state==TMO.
- FSM states: IDLE, RUN, DONE, TMO.
- IDLE:
  - start=1 latches cfg_pattern, cfg_target and cfg_timeout.
  - It clears the shift register, fill counter, bit counter and match_cnt.
  - Next state is RUN, or DONE directly if cfg_target==0.
  - match_cnt holds its last value while idle until the next accepted start.
- RUN, per cycle with din_valid=1:
  - Shift register updates as shreg <= {shreg[PAT_W-2:0], din}.
  - fill increments, saturating at PAT_W. bit_cnt increments.
  - A match occurs when the updated fill==PAT_W and the updated shreg==latched pattern.
  - Matches overlap: shreg is not cleared on a match.
  - On a match, match_cnt increments and match_pulse=1 in the following cycle.
- RUN, when din_valid=0: no state change, nothing counted.
- Termination, evaluated on the same valid bit:
  - If this bit's match makes match_cnt reach the latched target, go to DONE.
  - Otherwise, if the latched timeout!=0 and bit_cnt+1==timeout, go to TMO.
  - If both occur on the same bit, DONE wins.
- Latency: for a valid bit sampled at edge k, match_pulse, the updated match_cnt and done/timeout are all visible in cycle k+1 (same cycle as each other).
- DONE and TMO last exactly one cycle, then IDLE. din is ignored in these states.
- start is ignored in RUN, DONE and TMO. It is not queued.
- cfg_* inputs are don't-care outside the start cycle.
- match_cnt never exceeds the latched target. No wrap-around.
- bit_cnt never exceeds the latched timeout when timeout!=0. When timeout==0, bit_cnt wraps freely and has no effect.

Test Plan:
- Overlap: pattern=1011, target=2, timeout=0, stream 1,0,1,1,0,1,1 with din_valid=1 -> match_pulse after bits 4 and 7; done one cycle after bit 7 with match_cnt=2; busy falls at the same time; IDLE next.
- Timeout: pattern=1111, target=1, timeout=5, stream 1,0,1,0,1 -> timeout pulse after bit 5; match_cnt=0; done never asserts.
- Valid gaps and tie: pattern=1011, target=1, timeout=4, bits 1,0,1,1 with din_valid low for 3 cycles between bits 2 and 3 -> gaps are ignored; at bit 4 match and budget coincide -> done=1, timeout=0.
- target=0: start with cfg_target=0 -> busy never asserts; done pulses in the cycle after start; match_cnt=0.
- start ignored: assert start repeatedly during RUN with different cfg -> the job completes using the originally latched config; no second job starts.
- Async reset: assert rst mid-job, asynchronous to clk, after 1 match -> all outputs 0 immediately; after release, a new start runs cleanly from match_cnt=0.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// Job-based serial pattern detector: latches pattern/target/bit budget on start,
// counts overlapping matches and ends with a done or timeout pulse.
module seq_detect_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic [TMO_W-1:0] cfg_timeout,
    input  logic             din_valid,
    input  logic             din,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_cnt
);

    // state | meaning
    // IDLE  | waiting for start; match_cnt holds result of last job
    // RUN   | consuming valid bits, counting matches
    // DONE  | one cycle: target reached
    // TMO   | one cycle: bit budget exhausted
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_TMO  = 2'd3
    } state_t;

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    state_t state_q, state_d;

    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [CNT_W-1:0]  tgt_q, tgt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [PAT_W-1:0]  shreg_q, shreg_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [TMO_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;

    logic busy_q, busy_d;
    logic done_q, done_d;
    logic timeout_q, timeout_d;
    logic match_pulse_q, match_pulse_d;

    logic [PAT_W-1:0]  shreg_shift;
    logic [FILL_W-1:0] fill_inc;
    logic [TMO_W-1:0]  bit_inc;
    logic [CNT_W-1:0]  cnt_inc;
    logic              accept;
    logic              run_bit;
    logic              hit;
    logic              reach;
    logic              budget_out;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q         <= '0;
            tgt_q         <= '0;
            tmo_q         <= '0;
            shreg_q       <= '0;
            fill_q        <= '0;
            bit_cnt_q     <= '0;
            match_cnt_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            match_pulse_q <= 1'b0;
        end else begin
            pat_q         <= pat_d;
            tgt_q         <= tgt_d;
            tmo_q         <= tmo_d;
            shreg_q       <= shreg_d;
            fill_q        <= fill_d;
            bit_cnt_q     <= bit_cnt_d;
            match_cnt_q   <= match_cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
            match_pulse_q <= match_pulse_d;
        end
    end

    // match and termination conditions are judged on the post-shift view of the bit
    always_comb begin
        shreg_shift = {shreg_q[PAT_W-2:0], din};
        fill_inc    = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
        bit_inc     = bit_cnt_q + TMO_W'(1);
        cnt_inc     = match_cnt_q + CNT_W'(1);
        accept      = (state_q == ST_IDLE) && start;
        run_bit     = (state_q == ST_RUN) && din_valid;
        hit         = run_bit && (fill_inc == FILL_FULL) && (shreg_shift == pat_q);
        reach       = hit && (cnt_inc == tgt_q);
        budget_out  = run_bit && (tmo_q != '0) && (bit_inc == tmo_q);

        pat_d       = pat_q;
        tgt_d       = tgt_q;
        tmo_d       = tmo_q;
        shreg_d     = shreg_q;
        fill_d      = fill_q;
        bit_cnt_d   = bit_cnt_q;
        match_cnt_d = match_cnt_q;

        if (accept) begin
            pat_d       = cfg_pattern;
            tgt_d       = cfg_target;
            tmo_d       = cfg_timeout;
            shreg_d     = '0;
            fill_d      = '0;
            bit_cnt_d   = '0;
            match_cnt_d = '0;
        end else if (run_bit) begin
            shreg_d   = shreg_shift;
            fill_d    = fill_inc;
            bit_cnt_d = bit_inc;
            if (hit) begin
                match_cnt_d = cnt_inc;
            end
        end
    end

    // next-state logic; a match that reaches target beats an exhausted budget
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (cfg_target == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (reach) begin
                    state_d = ST_DONE;
                end else if (budget_out) begin
                    state_d = ST_TMO;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_TMO:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // outputs decoded from the next state so they land in the same register stage
    always_comb begin
        busy_d        = (state_d == ST_RUN);
        done_d        = (state_d == ST_DONE);
        timeout_d     = (state_d == ST_TMO);
        match_pulse_d = hit;
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign match_pulse = match_pulse_q;
    assign match_cnt   = match_cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed job scenarios plus random
// traffic, compared every cycle against a queue-based job model.
module tb_seq_detect_ctrl;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;
    localparam int TMO_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [PAT_W-1:0] cfg_pattern;
    logic [CNT_W-1:0] cfg_target;
    logic [TMO_W-1:0] cfg_timeout;
    logic             din_valid;
    logic             din;
    logic             busy;
    logic             done;
    logic             timeout;
    logic             match_pulse;
    logic [CNT_W-1:0] match_cnt;

    int n_chk = 0;
    int n_err = 0;

    seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_pattern (cfg_pattern),
        .cfg_target  (cfg_target),
        .cfg_timeout (cfg_timeout),
        .din_valid   (din_valid),
        .din         (din),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .match_pulse (match_pulse),
        .match_cnt   (match_cnt)
    );

    always #5 clk = ~clk;

    // job model: 0 idle, 1 running, 2 one-cycle ending
    int   m_phase;
    int   m_pat, m_tgt, m_tmo, m_nbits, m_cnt;
    bit   m_bits[$];
    logic e_busy, e_done, e_tmo, e_mp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_cnt   = 0;
        m_bits.delete();
        e_busy  = 1'b0;
        e_done  = 1'b0;
        e_tmo   = 1'b0;
        e_mp    = 1'b0;
    endtask

    task automatic model_step();
        int tail;
        e_done = 1'b0;
        e_tmo  = 1'b0;
        e_mp   = 1'b0;
        if (m_phase == 0) begin
            if (start) begin
                m_pat   = int'(cfg_pattern);
                m_tgt   = int'(cfg_target);
                m_tmo   = int'(cfg_timeout);
                m_nbits = 0;
                m_cnt   = 0;
                m_bits.delete();
                m_phase = (m_tgt == 0) ? 2 : 1;
                e_done  = (m_tgt == 0);
            end
        end else if (m_phase == 1) begin
            if (din_valid) begin
                m_bits.push_back(din);
                if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
                m_nbits++;
                if (m_bits.size() == PAT_W) begin
                    tail = 0;
                    for (int i = 0; i < PAT_W; i++) tail = (tail << 1) | int'(m_bits[i]);
                    if (tail == m_pat) begin
                        m_cnt++;
                        e_mp = 1'b1;
                    end
                end
                if (m_cnt == m_tgt) begin
                    e_done  = 1'b1;
                    m_phase = 2;
                end else if (m_tmo != 0 && m_nbits == m_tmo) begin
                    e_tmo   = 1'b1;
                    m_phase = 2;
                end
            end
        end else begin
            m_phase = 0;
        end
        e_busy = (m_phase == 1);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'(e_busy));
        chk({tag, "_done"}, 32'(done), 32'(e_done));
        chk({tag, "_tmo"}, 32'(timeout), 32'(e_tmo));
        chk({tag, "_mp"}, 32'(match_pulse), 32'(e_mp));
        chk({tag, "_cnt"}, 32'(match_cnt), 32'(m_cnt));
    endtask

    task automatic cyc(input string tag, input logic s, input logic [PAT_W-1:0] p,
                       input logic [CNT_W-1:0] t, input logic [TMO_W-1:0] to,
                       input logic v, input logic d);
        start       = s;
        cfg_pattern = p;
        cfg_target  = t;
        cfg_timeout = to;
        din_valid   = v;
        din         = d;
        model_step();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    logic [6:0] s1;
    logic [4:0] s2;
    logic [3:0] s3;

    initial begin
        rst = 1'b1;
        start = 1'b0; cfg_pattern = '0; cfg_target = '0; cfg_timeout = '0;
        din_valid = 1'b0; din = 1'b0;
        model_reset();
        #12;
        check_outputs("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        idle("rst_idle", 2);

        // overlapping matches of 1011 in 1011011 with start spammed during RUN
        s1 = 7'b1011011;
        cyc("ovl_start", 1'b1, 4'b1011, 8'd2, 16'd0, 1'b0, 1'b0);
        for (int i = 6; i >= 0; i--)
            cyc("ovl", 1'b1, 4'b1111, 8'd0, 16'd3, 1'b1, s1[i]);
        chk("ovl_final_cnt", 32'(match_cnt), 32'd2);
        chk("ovl_final_done", 32'(done), 32'd1);
        idle("ovl_tail", 2);

        // budget exhaustion without a match
        s2 = 5'b10101;
        cyc("tmo_start", 1'b1, 4'b1111, 8'd1, 16'd5, 1'b0, 1'b0);
        for (int i = 4; i >= 0; i--) cyc("tmo", 1'b0, '0, '0, '0, 1'b1, s2[i]);
        chk("tmo_final_pulse", 32'(timeout), 32'd1);
        chk("tmo_final_cnt", 32'(match_cnt), 32'd0);
        idle("tmo_tail", 2);

        // valid gaps, then match and budget on the same bit
        s3 = 4'b1011;
        cyc("gap_start", 1'b1, 4'b1011, 8'd1, 16'd4, 1'b0, 1'b0);
        cyc("gap", 1'b0, '0, '0, '0, 1'b1, s3[3]);
        cyc("gap", 1'b0, '0, '0, '0, 1'b1, s3[2]);
        for (int i = 0; i < 3; i++) cyc("gap_hole", 1'b0, '0, '0, '0, 1'b0, 1'b1);
        cyc("gap", 1'b0, '0, '0, '0, 1'b1, s3[1]);
        cyc("gap", 1'b0, '0, '0, '0, 1'b1, s3[0]);
        chk("tie_done", 32'(done), 32'd1);
        chk("tie_tmo", 32'(timeout), 32'd0);
        idle("gap_tail", 2);

        // zero target finishes immediately
        cyc("t0_start", 1'b1, 4'b0101, 8'd0, 16'd9, 1'b1, 1'b1);
        chk("t0_busy", 32'(busy), 32'd0);
        chk("t0_done", 32'(done), 32'd1);
        idle("t0_tail", 2);

        // async reset mid-job after one match
        cyc("ar_start", 1'b1, 4'b0110, 8'd3, 16'd0, 1'b0, 1'b0);
        cyc("ar", 1'b0, '0, '0, '0, 1'b1, 1'b0);
        cyc("ar", 1'b0, '0, '0, '0, 1'b1, 1'b1);
        cyc("ar", 1'b0, '0, '0, '0, 1'b1, 1'b1);
        cyc("ar", 1'b0, '0, '0, '0, 1'b1, 1'b0);
        cyc("ar", 1'b0, '0, '0, '0, 1'b1, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("ar_async");
        @(posedge clk); #1;
        rst = 1'b0;
        idle("ar_idle", 1);
        cyc("ar2_start", 1'b1, 4'b0110, 8'd1, 16'd0, 1'b0, 1'b0);
        chk("ar2_cnt_clear", 32'(match_cnt), 32'd0);
        cyc("ar2", 1'b0, '0, '0, '0, 1'b1, 1'b0);
        cyc("ar2", 1'b0, '0, '0, '0, 1'b1, 1'b1);
        cyc("ar2", 1'b0, '0, '0, '0, 1'b1, 1'b1);
        cyc("ar2", 1'b0, '0, '0, '0, 1'b1, 1'b0);
        idle("ar2_tail", 2);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            cyc("rnd",
                ($urandom_range(0, 3) == 0),
                PAT_W'($urandom_range(0, 15)),
                CNT_W'($urandom_range(0, 4)),
                TMO_W'($urandom_range(0, 24)),
                ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
